// File: rtl/cond_flag_unit.sv
// Execute-stage condition unit: holds the NZCV register, evaluates the condition
// field against it and gates register/memory/PC/flag side effects of each instruction.
module cond_flag_unit #(
    parameter logic [3:0] FLAGS_INIT = 4'b0000,
    parameter bit         HOLD_COND  = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       issue,
    input  logic       stall,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       no_write,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       pcs,
    output logic       cond_ex,
    output logic       cond_ex_q,
    output logic       reg_write,
    output logic       mem_write,
    output logic       pc_src,
    output logic [3:0] flags,
    output logic       carry
);

    typedef enum logic [3:0] {
        CC_EQ = 4'b0000, CC_NE = 4'b0001, CC_CS = 4'b0010, CC_CC = 4'b0011,
        CC_MI = 4'b0100, CC_PL = 4'b0101, CC_VS = 4'b0110, CC_VC = 4'b0111,
        CC_HI = 4'b1000, CC_LS = 4'b1001, CC_GE = 4'b1010, CC_LT = 4'b1011,
        CC_GT = 4'b1100, CC_LE = 4'b1101, CC_AL = 4'b1110, CC_NV = 4'b1111
    } cc_e;

    logic [3:0] flags_q, flags_d;
    logic       cex_q, cex_d;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       issue_g, fire, go;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Condition only ever looks at the registered flags, so an instruction that
    // writes flags (e.g. ADDEQS) is predicated on the values from before it.
    always_comb begin
        cond_ex = 1'b0;
        case (cc_e'(cond))
            CC_EQ: cond_ex = flag_z;
            CC_NE: cond_ex = ~flag_z;
            CC_CS: cond_ex = flag_c;
            CC_CC: cond_ex = ~flag_c;
            CC_MI: cond_ex = flag_n;
            CC_PL: cond_ex = ~flag_n;
            CC_VS: cond_ex = flag_v;
            CC_VC: cond_ex = ~flag_v;
            CC_HI: cond_ex = flag_c & ~flag_z;
            CC_LS: cond_ex = ~flag_c | flag_z;
            CC_GE: cond_ex = (flag_n == flag_v);
            CC_LT: cond_ex = (flag_n != flag_v);
            CC_GT: cond_ex = ~flag_z & (flag_n == flag_v);
            CC_LE: cond_ex = flag_z | (flag_n != flag_v);
            CC_AL: cond_ex = 1'b1;
            CC_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

    // issue is gated first so X on the other decoder inputs cannot leak when idle,
    // and reset_n is folded in so every gated output reads 0 during reset.
    assign issue_g = issue & reset_n;
    assign fire    = issue_g & ~stall;
    assign go      = fire & cond_ex;

    assign reg_write = go & reg_w & ~no_write;
    assign mem_write = go & mem_w;
    assign pc_src    = go & pcs;

    always_comb begin
        flags_d = flags_q;
        if (go && flag_w[1]) begin
            flags_d[3:2] = alu_flags[3:2];
        end
        if (go && flag_w[0]) begin
            flags_d[1:0] = alu_flags[1:0];
        end
    end

    generate
        if (HOLD_COND) begin : g_hold
            assign cex_d = fire ? cond_ex : cex_q;
        end else begin : g_free
            assign cex_d = cond_ex;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= FLAGS_INIT;
            cex_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            cex_q   <= cex_d;
        end
    end

    assign flags     = flags_q;
    assign carry     = flags_q[1];
    assign cond_ex_q = cex_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed + randomized bench for cond_flag_unit with a reference flag model and
// an expectation scoreboard drained after each settle point.
module tb_cond_flag_unit;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       issue = 1'b0;
    logic       stall = 1'b0;
    logic [3:0] cond = 4'b0000;
    logic [3:0] alu_flags = 4'b0000;
    logic [1:0] flag_w = 2'b00;
    logic       no_write = 1'b0;
    logic       reg_w = 1'b0;
    logic       mem_w = 1'b0;
    logic       pcs = 1'b0;
    logic       cond_ex, cond_ex_q, reg_write, mem_write, pc_src, carry;
    logic [3:0] flags;

    int total = 0;
    int bad = 0;

    localparam int S_CE = 0, S_CEQ = 1, S_RW = 2, S_MW = 3, S_PC = 4, S_FL = 5, S_CY = 6;

    typedef struct {
        string      tag;
        int         sel;
        logic [3:0] exp;
    } sb_t;

    sb_t sb[$];

    logic [3:0] m_flags = 4'b0000;
    logic       m_ceq = 1'b0;

    cond_flag_unit #(.FLAGS_INIT(4'b0000), .HOLD_COND(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .issue(issue), .stall(stall), .cond(cond),
        .alu_flags(alu_flags), .flag_w(flag_w), .no_write(no_write), .reg_w(reg_w),
        .mem_w(mem_w), .pcs(pcs), .cond_ex(cond_ex), .cond_ex_q(cond_ex_q),
        .reg_write(reg_write), .mem_write(mem_write), .pc_src(pc_src),
        .flags(flags), .carry(carry)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic cond_pass(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] obs(input int sel);
        case (sel)
            S_CE:  return {3'b000, cond_ex};
            S_CEQ: return {3'b000, cond_ex_q};
            S_RW:  return {3'b000, reg_write};
            S_MW:  return {3'b000, mem_write};
            S_PC:  return {3'b000, pc_src};
            S_FL:  return flags;
            S_CY:  return {3'b000, carry};
            default: return 4'bxxxx;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [3:0] exp);
        sb_t e;
        e.tag = tag; e.sel = sel; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        logic [3:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            total++;
            assert (o === e.exp) else begin
                bad++;
                $error("FAIL %s observed=%b expected=%b", e.tag, o, e.exp);
            end
        end
    endtask

    // One clocked instruction: drive at negedge, check combinational outputs, then state after posedge.
    task automatic step(input string nm, input logic i, input logic s, input logic [3:0] c,
                        input logic [1:0] fw, input logic [3:0] af, input logic nw,
                        input logic rw, input logic mw, input logic pc);
        logic ce, g;
        @(negedge clk);
        issue = i; stall = s; cond = c; flag_w = fw; alu_flags = af;
        no_write = nw; reg_w = rw; mem_w = mw; pcs = pc;
        ce = cond_pass(m_flags, c);
        g  = i & !s & ce;
        if (!$isunknown(c)) push({nm, ".cond_ex"}, S_CE, {3'b000, ce});
        push({nm, ".reg_write"}, S_RW, {3'b000, g & rw & !nw});
        push({nm, ".mem_write"}, S_MW, {3'b000, g & mw});
        push({nm, ".pc_src"}, S_PC, {3'b000, g & pc});
        #1 drain();
        @(posedge clk);
        if (g && fw[1]) m_flags[3:2] = af[3:2];
        if (g && fw[0]) m_flags[1:0] = af[1:0];
        if (i && !s) m_ceq = ce;
        #1;
        push({nm, ".flags"}, S_FL, m_flags);
        push({nm, ".carry"}, S_CY, {3'b000, m_flags[1]});
        push({nm, ".cond_ex_q"}, S_CEQ, {3'b000, m_ceq});
        drain();
        $display("step %s issue=%b stall=%b cond=%b flags=%b", nm, i, s, c, flags);
    endtask

    initial begin
        // Reset with an AL register write presented.
        issue = 1'b1; cond = 4'b1110; reg_w = 1'b1;
        #12;
        push("rst.reg_write", S_RW, 4'b0000);
        push("rst.flags", S_FL, 4'b0000);
        push("rst.cond_ex_q", S_CEQ, 4'b0000);
        drain();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        push("rel.reg_write", S_RW, 4'b0001);
        drain();
        issue = 1'b0; reg_w = 1'b0;

        // CMP then BEQ.
        step("cmp", 1, 0, 4'b1110, 2'b11, 4'b0100, 1, 1, 0, 0);
        push("cmp.flags_const", S_FL, 4'b0100);
        drain();
        step("beq", 1, 0, 4'b0000, 2'b00, 4'b0000, 0, 0, 0, 1);

        // ADDEQS uses the old flags; ADDNES then writes.
        step("clr", 1, 0, 4'b1110, 2'b11, 4'b0000, 0, 0, 0, 0);
        step("addeqs", 1, 0, 4'b0000, 2'b11, 4'b1111, 0, 1, 0, 0);
        push("addeqs.flags_const", S_FL, 4'b0000);
        drain();
        step("addnes", 1, 0, 4'b0001, 2'b11, 4'b1111, 0, 1, 0, 0);
        push("addnes.flags_const", S_FL, 4'b1111);
        drain();

        // Partial write: N,Z only.
        step("set0011", 1, 0, 4'b1110, 2'b11, 4'b0011, 0, 0, 0, 0);
        step("muls", 1, 0, 4'b1110, 2'b10, 4'b1000, 0, 1, 0, 0);
        push("muls.flags_const", S_FL, 4'b1011);
        push("muls.carry_const", S_CY, 4'b0001);
        drain();

        // Signed conditions.
        step("setN", 1, 0, 4'b1110, 2'b11, 4'b1000, 0, 0, 0, 0);
        step("lt", 1, 0, 4'b1011, 2'b00, 4'b0000, 0, 1, 0, 0);
        step("gt", 1, 0, 4'b1100, 2'b00, 4'b0000, 0, 1, 0, 0);
        step("setZ", 1, 0, 4'b1110, 2'b11, 4'b0100, 0, 0, 0, 0);
        step("le", 1, 0, 4'b1101, 2'b00, 4'b0000, 0, 1, 0, 0);

        // Stall: cond_ex_q primed to 0 by a failing NE, then a stalled AL update.
        step("ne_fail", 1, 0, 4'b0001, 2'b00, 4'b0000, 0, 0, 0, 0);
        step("stall", 1, 1, 4'b1110, 2'b11, 4'b1111, 0, 0, 1, 0);
        push("stall.flags_const", S_FL, 4'b0100);
        push("stall.ceq_const", S_CEQ, 4'b0000);
        drain();
        step("unstall", 1, 0, 4'b1110, 2'b11, 4'b1111, 0, 0, 1, 0);
        push("unstall.flags_const", S_FL, 4'b1111);
        drain();

        // Idle cycle with X on decoder inputs must not disturb anything.
        step("idle_x", 0, 0, 4'bxxxx, 2'bxx, 4'bxxxx, 1'bx, 1, 1, 1);

        // Randomized instruction stream against the model.
        for (int k = 0; k < 60; k++) begin
            step($sformatf("rnd%0d", k), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 4'($urandom), 2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
        end

        // Reset asserted mid-instruction discards the pending update.
        @(negedge clk);
        issue = 1'b1; stall = 1'b0; cond = 4'b1110; flag_w = 2'b11; alu_flags = 4'b1010;
        reg_w = 1'b1; no_write = 1'b0;
        #2 reset_n = 1'b0;
        m_flags = 4'b0000; m_ceq = 1'b0;
        #1;
        push("midrst.reg_write", S_RW, 4'b0000);
        push("midrst.flags", S_FL, 4'b0000);
        drain();
        @(posedge clk);
        #1;
        push("midrst.flags_after_edge", S_FL, 4'b0000);
        push("midrst.ceq_after_edge", S_CEQ, 4'b0000);
        drain();
        @(negedge clk);
        issue = 1'b0;
        reset_n = 1'b1;
        step("post_rst", 1, 0, 4'b0000, 2'b01, 4'b0011, 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Execute-stage condition unit directly downstream of the ALU decoder.
- Holds the architectural NZCV flags register and evaluates each instruction's 4-bit condition field against it.
- Gates the architectural side effects of each instruction: register write, memory write, PC redirect and flag update.
- Supplies the registered carry to the ALU for ADC/SBC/RSC.

Parameters:
- FLAGS_INIT, 4'b0000, NZCV value loaded on reset (bit3=N, bit2=Z, bit1=C, bit0=V).
- HOLD_COND, 1, when 1, cond_ex_q holds the last evaluated result between issue strobes (for the multicycle FSM); when 0, it updates every cycle.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- issue  input  1  instruction valid in execute this cycle; side effects only occur when issue=1
- stall  input  1  pipeline hold; it overrides issue: no flag update and outputs gated low
- cond  input  4  instruction condition field [31:28]
- alu_flags  input  4  NZCV produced by the ALU for the current instruction
- flag_w  input  2  from the ALU decoder; [1] writes N,Z; [0] writes C,V
- no_write  input  1  from the ALU decoder; CMP/CMN/TST/TEQ: suppresses the register write
- reg_w  input  1  main-decoder register write request
- mem_w  input  1  main-decoder memory write request
- pcs  input  1  PC-source request (branch, or a write to R15)
- cond_ex  output  1  combinational condition pass for the current instruction
- cond_ex_q  output  1  registered cond_ex
- reg_write  output  1  gated register write
- mem_write  output  1  gated memory write
- pc_src  output  1  gated PC redirect
- flags  output  4  current NZCV register value
- carry  output  1  flags[1], to the ALU carry-in

Behaviour:
- Reset, asynchronous on reset_n low:
  - flags=FLAGS_INIT.
  - cond_ex_q=0.
  - All gated outputs read 0 while reset_n=0, because the combinational gating forces issue low during reset.
- Condition evaluation, combinational on the flags register only (never on alu_flags):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 0 (unconditional space not supported).
- Define go = issue & !stall & cond_ex.
- Gated outputs:
  - reg_write = go & reg_w & !no_write.
  - mem_write = go & mem_w.
  - pc_src = go & pcs.
- Flag update on the rising clk edge when go=1:
  - If flag_w[1]: N,Z <= alu_flags[3:2].
  - If flag_w[0]: C,V <= alu_flags[1:0].
  - Untouched bits hold. A multiply with S set (flag_w=10) leaves C,V unchanged.
- Latency:
  - Flags written by instruction k are visible to the condition of instruction k+1 on the next clock.
  - Within one cycle the condition always uses the old flags, even when the same instruction writes flags (e.g. ADDEQS).
- cond_ex_q:
  - HOLD_COND=1: loads cond_ex on the edge where issue&!stall, otherwise holds.
  - HOLD_COND=0: loads cond_ex every edge.
- Stall: while stall=1, flags and cond_ex_q (HOLD_COND=1) are frozen and all gated outputs are 0. cond_ex itself is still driven.
- Failed condition: the instruction is a NOP; no flag, register, memory or PC effect.
- Reset mid-instruction: any flag update pending at that edge is discarded; flags=FLAGS_INIT.
- X handling: when issue=0, X on flag_w, no_write or cond must not propagate into flags or the gated outputs. Gate with issue first.

Test Plan:
- Reset sequence: reset_n=0 with issue=1, cond=1110, reg_w=1 -> reg_write=0, flags=0000; release reset, same inputs -> reg_write=1.
- CMP then BEQ:
  - Cycle 0: issue, cond=1110, flag_w=11, alu_flags=0100, no_write=1, reg_w=1 -> reg_write=0.
  - Cycle 1: cond=0000, pcs=1 -> pc_src=1, flags=0100.
- Same-cycle use of old flags: flags=0000, ADDEQS (cond=0000, flag_w=11, alu_flags=1111) -> cond_ex=0, flags stay 0000; repeat with cond=0001 -> flags become 1111 next cycle.
- Partial write: flags=0011, flag_w=10, alu_flags=1000 -> flags=1011; carry stays 1.
- Signed conditions:
  - flags N=1,V=0, cond=1011 (LT) -> cond_ex=1.
  - cond=1100 (GT) -> cond_ex=0.
  - flags Z=1, cond=1101 (LE) -> cond_ex=1.
- Stall: stall=1, issue=1, cond=1110, flag_w=11, alu_flags=1111, mem_w=1 -> mem_write=0, flags unchanged, cond_ex_q held; deassert stall -> update occurs.
